multicycle_ctrl: RTL and testbench

//  Moore FSM control unit for the multicycle MIPS datapath. Sequences each instruction through

---
 rtl/multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle MIPS datapath.
// Each instruction goes through fetch, decode and execute, plus memory and
// writeback where the instruction needs them. The FSM drives every datapath
// mux select and write enable. Overflow on add, sub or addi traps to the
// exception vector.
module multicycle_ctrl #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       a_write,
    output logic       b_write,
    output logic       alu_out_write,
    output logic       mux_a_control,
    output logic [1:0] mux_b_control,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       epc_write,
    output logic       illegal,
    output logic [3:0] state_out
);

    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_R_WB   = 4'd4,
        S_EXEC_I = 4'd5,
        S_I_WB   = 4'd6,
        S_ADDR   = 4'd7,
        S_MEM_RD = 4'd8,
        S_MEM_WB = 4'd9,
        S_MEM_WR = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_OVF    = 4'd13
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          wait_last;
    logic          fn_addsub;

    // The branch decision (zero) is taken in the datapath through pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

    assign wait_last = (cnt == CW'(MEM_WAIT - 1));
    assign fn_addsub = (funct == FN_ADD) || (funct == FN_SUB);

    // State register and memory-wait counter with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values from before the edge.
        if (reset) begin
            state <= S_RESET;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic and Moore decode of the datapath controls.
    always_comb begin
        // NOTE: every output gets a default before the case statement, so no
        // path through this block can leave a latch behind.
        state_next    = state;
        cnt_next      = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_wr        = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        a_write       = 1'b0;
        b_write       = 1'b0;
        alu_out_write = 1'b0;
        mux_a_control = 1'b0;
        mux_b_control = 2'b00;
        alu_op        = 3'b000;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        epc_write     = 1'b0;
        illegal       = 1'b0;
        state_out     = state;

        case (state)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                mux_b_control = 2'b01;
                alu_op        = ALU_ADD;
                if (wait_last) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_DECODE: begin
                a_write       = 1'b1;
                b_write       = 1'b1;
                mux_b_control = 2'b11;
                alu_op        = ALU_ADD;
                alu_out_write = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        if (fn_addsub || funct == FN_AND) begin
                            state_next = S_EXEC_R;
                        end else begin
                            illegal    = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                    OP_ADDI:      state_next = S_EXEC_I;
                    OP_LW, OP_SW: state_next = S_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                mux_a_control = 1'b1;
                alu_out_write = 1'b1;
                case (funct)
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
                state_next = (overflow && fn_addsub) ? S_OVF : S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = S_FETCH;
            end
            S_EXEC_I: begin
                mux_a_control = 1'b1;
                mux_b_control = 2'b10;
                alu_op        = ALU_ADD;
                alu_out_write = 1'b1;
                state_next    = overflow ? S_OVF : S_I_WB;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_ADDR: begin
                mux_a_control = 1'b1;
                mux_b_control = 2'b10;
                alu_op        = ALU_ADD;
                alu_out_write = 1'b1;
                state_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                i_or_d = 1'b1;
                if (wait_last) begin
                    mdr_write  = 1'b1;
                    state_next = S_MEM_WB;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                i_or_d     = 1'b1;
                mem_wr     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                mux_a_control = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                state_next = S_FETCH;
            end
            S_OVF: begin
                epc_write  = 1'b1;
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                state_next = S_FETCH;
            end
            default: state_next = S_RESET;
        endcase

        // While reset is high, hold every output low. This also stops a
        // pending write in the cycle that reset aborts.
        if (reset) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            pc_source     = 2'b00;
            i_or_d        = 1'b0;
            mem_wr        = 1'b0;
            ir_write      = 1'b0;
            mdr_write     = 1'b0;
            a_write       = 1'b0;
            b_write       = 1'b0;
            alu_out_write = 1'b0;
            mux_a_control = 1'b0;
            mux_b_control = 2'b00;
            alu_op        = 3'b000;
            reg_write     = 1'b0;
            reg_dst       = 1'b0;
            mem_to_reg    = 1'b0;
            epc_write     = 1'b0;
            illegal       = 1'b0;
            state_out     = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl.
// Stimulus pushes the expected control word for each cycle into a queue.
// A separate monitor pops one entry per cycle and compares it with the DUT.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_wr;
        logic       ir_write;
        logic       mdr_write;
        logic       a_write;
        logic       b_write;
        logic       alu_out_write;
        logic       mux_a;
        logic [1:0] mux_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       epc_write;
        logic       illegal;
        logic [3:0] state;
    } ctrl_t;

    // Expected control words, one per state / cycle flavour.
    localparam ctrl_t E_ZERO    = '{default: '0};
    localparam ctrl_t E_F0      = '{state: 4'd1, mux_b: 2'b01, alu_op: 3'b001, default: '0};
    localparam ctrl_t E_F1      = '{state: 4'd1, mux_b: 2'b01, alu_op: 3'b001, ir_write: 1'b1,
                                    pc_write: 1'b1, default: '0};
    localparam ctrl_t E_DEC     = '{state: 4'd2, a_write: 1'b1, b_write: 1'b1, mux_b: 2'b11,
                                    alu_op: 3'b001, alu_out_write: 1'b1, default: '0};
    localparam ctrl_t E_DEC_ILL = '{state: 4'd2, a_write: 1'b1, b_write: 1'b1, mux_b: 2'b11,
                                    alu_op: 3'b001, alu_out_write: 1'b1, illegal: 1'b1, default: '0};
    localparam ctrl_t E_EXR_ADD = '{state: 4'd3, mux_a: 1'b1, alu_op: 3'b001, alu_out_write: 1'b1,
                                    default: '0};
    localparam ctrl_t E_EXR_SUB = '{state: 4'd3, mux_a: 1'b1, alu_op: 3'b010, alu_out_write: 1'b1,
                                    default: '0};
    localparam ctrl_t E_EXR_AND = '{state: 4'd3, mux_a: 1'b1, alu_op: 3'b011, alu_out_write: 1'b1,
                                    default: '0};
    localparam ctrl_t E_RWB     = '{state: 4'd4, reg_write: 1'b1, reg_dst: 1'b1, default: '0};
    localparam ctrl_t E_EXI     = '{state: 4'd5, mux_a: 1'b1, mux_b: 2'b10, alu_op: 3'b001,
                                    alu_out_write: 1'b1, default: '0};
    localparam ctrl_t E_IWB     = '{state: 4'd6, reg_write: 1'b1, default: '0};
    localparam ctrl_t E_ADDR    = '{state: 4'd7, mux_a: 1'b1, mux_b: 2'b10, alu_op: 3'b001,
                                    alu_out_write: 1'b1, default: '0};
    localparam ctrl_t E_MRD0    = '{state: 4'd8, i_or_d: 1'b1, default: '0};
    localparam ctrl_t E_MRD1    = '{state: 4'd8, i_or_d: 1'b1, mdr_write: 1'b1, default: '0};
    localparam ctrl_t E_MWB     = '{state: 4'd9, reg_write: 1'b1, mem_to_reg: 1'b1, default: '0};
    localparam ctrl_t E_MWR     = '{state: 4'd10, i_or_d: 1'b1, mem_wr: 1'b1, default: '0};
    localparam ctrl_t E_BR      = '{state: 4'd11, mux_a: 1'b1, alu_op: 3'b010, pc_write_cond: 1'b1,
                                    pc_source: 2'b01, default: '0};
    localparam ctrl_t E_J       = '{state: 4'd12, pc_write: 1'b1, pc_source: 2'b10, default: '0};
    localparam ctrl_t E_OVF     = '{state: 4'd13, epc_write: 1'b1, pc_write: 1'b1,
                                    pc_source: 2'b11, default: '0};

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       pc_write, pc_write_cond, i_or_d, mem_wr, ir_write, mdr_write;
    logic       a_write, b_write, alu_out_write, mux_a_control;
    logic       reg_write, reg_dst, mem_to_reg, epc_write, illegal;
    logic [1:0] pc_source, mux_b_control;
    logic [2:0] alu_op;
    logic [3:0] state_out;
    ctrl_t      got;

    int    checks = 0;
    int    errors = 0;
    ctrl_t exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT(2)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_wr(mem_wr), .ir_write(ir_write), .mdr_write(mdr_write),
        .a_write(a_write), .b_write(b_write), .alu_out_write(alu_out_write),
        .mux_a_control(mux_a_control), .mux_b_control(mux_b_control), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .epc_write(epc_write), .illegal(illegal), .state_out(state_out)
    );

    assign got = {pc_write, pc_write_cond, pc_source, i_or_d, mem_wr, ir_write, mdr_write,
                  a_write, b_write, alu_out_write, mux_a_control, mux_b_control, alu_op,
                  reg_write, reg_dst, mem_to_reg, epc_write, illegal, state_out};

    // Monitor: one expected word per cycle, compared mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctrl_t e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, got, e);
        end
    end

    task automatic check(input string n, input ctrl_t actual, input ctrl_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d) at %0t",
                     n, actual, actual.state, expected, expected.state, $time);
        end
    endtask

    // Issue one cycle: queue its expected word, then advance past the next edge.
    task automatic cyc(input ctrl_t e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [5:0] op, input logic [5:0] fn, input string n);
        opcode = op;
        funct  = fn;
        cyc(E_F0, {n, "_fetch0"});
        cyc(E_F1, {n, "_fetch1"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        opcode   = 6'h00;
        funct    = 6'h00;
        zero     = 1'b0;
        overflow = 1'b0;
        @(posedge clk);
        #2;

        // Reset held for three cycles, then the single RESET cycle.
        repeat (3) cyc(E_ZERO, "in_reset");
        reset = 1'b0;
        cyc(E_ZERO, "reset_state");

        // add, no overflow.
        start(6'h00, 6'h20, "add");
        cyc(E_DEC, "add_decode");
        cyc(E_EXR_ADD, "add_exec");
        cyc(E_RWB, "add_wb");

        // lw: 7 cycles in total.
        start(6'h23, 6'h00, "lw");
        cyc(E_DEC, "lw_decode");
        cyc(E_ADDR, "lw_addr");
        cyc(E_MRD0, "lw_memrd0");
        cyc(E_MRD1, "lw_memrd1");
        cyc(E_MWB, "lw_wb");

        // sw.
        start(6'h2B, 6'h00, "sw");
        cyc(E_DEC, "sw_decode");
        cyc(E_ADDR, "sw_addr");
        cyc(E_MWR, "sw_memwr");

        // beq, taken and not taken: the FSM sequence is the same either way.
        zero = 1'b1;
        start(6'h04, 6'h00, "beq_z1");
        cyc(E_DEC, "beq_z1_decode");
        cyc(E_BR, "beq_z1_branch");
        zero = 1'b0;
        start(6'h04, 6'h00, "beq_z0");
        cyc(E_DEC, "beq_z0_decode");
        cyc(E_BR, "beq_z0_branch");

        // j.
        start(6'h02, 6'h00, "j");
        cyc(E_DEC, "j_decode");
        cyc(E_J, "j_jump");

        // addi with overflow traps; addi without overflow writes back.
        start(6'h08, 6'h00, "addi_ovf");
        cyc(E_DEC, "addi_ovf_decode");
        overflow = 1'b1;
        cyc(E_EXI, "addi_ovf_exec");
        overflow = 1'b0;
        cyc(E_OVF, "addi_ovf_trap");
        start(6'h08, 6'h00, "addi");
        cyc(E_DEC, "addi_decode");
        cyc(E_EXI, "addi_exec");
        cyc(E_IWB, "addi_wb");

        // sub with overflow traps; and ignores overflow.
        start(6'h00, 6'h22, "sub_ovf");
        cyc(E_DEC, "sub_ovf_decode");
        overflow = 1'b1;
        cyc(E_EXR_SUB, "sub_ovf_exec");
        overflow = 1'b0;
        cyc(E_OVF, "sub_ovf_trap");
        start(6'h00, 6'h24, "and_ovf");
        cyc(E_DEC, "and_ovf_decode");
        overflow = 1'b1;
        cyc(E_EXR_AND, "and_ovf_exec");
        overflow = 1'b0;
        cyc(E_RWB, "and_ovf_wb");

        // Unknown opcode and unknown funct: illegal pulse, straight back to FETCH.
        start(6'h3F, 6'h00, "bad_op");
        cyc(E_DEC_ILL, "bad_op_decode");
        start(6'h00, 6'h21, "bad_fn");
        cyc(E_DEC_ILL, "bad_fn_decode");

        // Reset in the last MEM_RD cycle: no mdr_write, then RESET and FETCH.
        start(6'h23, 6'h00, "lw_abort");
        cyc(E_DEC, "lw_abort_decode");
        cyc(E_ADDR, "lw_abort_addr");
        cyc(E_MRD0, "lw_abort_memrd0");
        reset = 1'b1;
        cyc(E_ZERO, "lw_abort_reset");
        reset = 1'b0;
        cyc(E_ZERO, "lw_abort_reset_state");
        start(6'h00, 6'h20, "after_abort");
        cyc(E_DEC, "after_abort_decode");

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
